miriscv_lsu: RTL and testbench
==============================

MIRISCV_LSU -- requirements
Module: miriscv_lsu

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255, max cycles in BUSY without data_ack_i before abort; range 1..255.
REQ-002 clk_i  input  1  core clock; all state updates on rising edge.
REQ-003 arstn_i  input  1  asynchronous active-low reset.
REQ-004 lsu_req_i  input  1  core memory request (decoder mem_req), held until stall drops.
REQ-005 lsu_we_i  input  1  1 = store, 0 = load.
REQ-006 lsu_size_i  input  3  decoder mem_size: 000 sb, 001 sh, 010 w, 100 ub, 101 uh.
REQ-007 lsu_addr_i  input  32  byte address from ALU.
REQ-008 lsu_data_i  input  32  store data (rs2).
REQ-009 lsu_data_o  output  32  registered, aligned, extended load result.
REQ-010 lsu_stall_req_o  output  1  core pipeline stall.
REQ-011 lsu_err_o  output  1  one-cycle error pulse (illegal size, timeout, misalign when enabled).
REQ-012 data_req_o / data_we_o  output  1 / 1  memory request / write enable.
REQ-013 data_be_o  output  4  byte enables.
REQ-014 data_addr_o / data_wdata_o  output  32 / 32  word-aligned address ({addr[31:2],2'b00}) / lane-replicated data.
REQ-015 data_ack_i / data_rdata_i  input  1 / 32  memory completion / read word, valid in ack cycle.

Function
REQ-016 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-017 IDLE + lsu_req_i: register addr, we, size, wdata; -> BUSY; illegal size -> DONE with lsu_err_o, no memory access.
REQ-018 BUSY: data_req_o=1 and address/we/be/wdata held stable every cycle until data_ack_i.
REQ-019 BUSY + data_ack_i: load -> lsu_data_o registered; -> DONE.
REQ-020 DONE: -> IDLE unconditionally next cycle; no request issued in DONE.
REQ-021 lsu_stall_req_o = lsu_req_i AND state != DONE (combinational); minimum access latency 2 cycles from lsu_req_i to stall release.
REQ-022 Byte store: be = 4'b0001 << addr[1:0], wdata = {4{data[7:0]}}; half: be = 4'b0011 << {addr[1],1'b0}, wdata = {2{data[15:0]}}; word: be = 4'b1111.
REQ-023 Load extraction: lane per addr[1:0]; size[2]=0 sign-extends, size[2]=1 zero-extends to 32 bits.
REQ-024 data_be_o = 4'b1111 for loads.
REQ-025 8-bit timeout counter cleared on entering BUSY, incremented per BUSY cycle without ack; reaching ACK_TIMEOUT -> DONE, lsu_err_o pulse, lsu_data_o unchanged.
REQ-026 data_ack_i outside BUSY ignored; ack in same cycle as timeout wins (normal completion, no error).
REQ-027 lsu_err_o asserted only during the DONE cycle of the failing access.
REQ-028 Stores never update lsu_data_o.

Reset
REQ-029 arstn_i low forces immediately: state IDLE, data_req_o 0, data_we_o 0, data_be_o 0, data_addr_o 0, data_wdata_o 0, lsu_data_o 0, lsu_err_o 0, counter 0.
REQ-030 Reset during BUSY abandons the access; no retry after reset release.

Configuration
REQ-031 Macro MIRISCV_LSU_MISALIGN_EXC_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> DONE with lsu_err_o, no memory request.
REQ-032 Macro undefined: misalignment not checked; low address bits ignored beyond REQ-022/023 lane selection (half uses addr[1], word none).

Verification
REQ-033 sw addr 0x100, data 0xDEADBEEF, ack 1 cycle after data_req_o -> be 1111, addr 0x100, stall low in cycle 3, err 0.
REQ-034 lb addr 0x103, rdata 0x80FF_FFFF -> lsu_data_o 0xFFFFFF80; lbu same -> 0x00000080.
REQ-035 sh addr 0x102, data 0x1234ABCD -> be 1100, wdata 0xABCDABCD.
REQ-036 lw, no ack, ACK_TIMEOUT=4 -> data_req_o high 4 cycles, then err pulse, stall released, IDLE.
REQ-037 lh addr 0x101 with macro -> no data_req_o, err pulse in cycle 2; without macro -> access issued, lane addr[1]=0.
REQ-038 arstn_i low mid-BUSY -> data_req_o 0 same cycle; after release, IDLE with all outputs 0.

Source files
------------

// File: rtl/miriscv_lsu_if.sv
// Memory-side bus of the miriscv load/store unit: request channel plus ack/read-data return.
// The LSU connects through the master modport; a memory or bus bridge connects through slave.
interface miriscv_lsu_if;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_ack_i;
    logic [31:0] data_rdata_i;

    modport master (
        output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        input  data_ack_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        output data_ack_i, data_rdata_i
    );
endinterface

// File: rtl/miriscv_lsu.sv
// miriscv load/store unit: IDLE/BUSY/DONE request FSM with byte-lane steering, load extension and ack timeout.
// Optional MIRISCV_LSU_MISALIGN_EXC_EN rejects misaligned half/word accesses with an error pulse.
module miriscv_lsu #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic               clk_i,
    input  logic               arstn_i,
    input  logic               lsu_req_i,
    input  logic               lsu_we_i,
    input  logic [2:0]         lsu_size_i,
    input  logic [31:0]        lsu_addr_i,
    input  logic [31:0]        lsu_data_i,
    output logic [31:0]        lsu_data_o,
    output logic               lsu_stall_req_o,
    output logic               lsu_err_o,
    miriscv_lsu_if.master      mem
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Last counter value that still waits; with no ack in that cycle the access is aborted.
    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [3:0]  be_q;
    logic [2:0]  size_q;
    logic        we_q;
    logic [7:0]  cnt_q;
    logic        err_q;

    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic        size_ok;
    logic        misalign;
    logic        req_fault;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;

    // Request decode: lane steering for stores, legality checks for all accesses.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = lsu_data_i;
        if (lsu_we_i) begin
            case (lsu_size_i[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << lsu_addr_i[1:0];
                    wdata_d = {4{lsu_data_i[7:0]}};
                end
                2'b01: begin
                    be_d    = 4'b0011 << {lsu_addr_i[1], 1'b0};
                    wdata_d = {2{lsu_data_i[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = lsu_data_i;
                end
            endcase
        end
    end

    assign size_ok = (lsu_size_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});

`ifdef MIRISCV_LSU_MISALIGN_EXC_EN
    assign misalign = ((lsu_size_i[1:0] == 2'b01) && lsu_addr_i[0]) ||
                      ((lsu_size_i[1:0] == 2'b10) && (lsu_addr_i[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_fault = !size_ok || misalign;

    // Lane extraction uses the address/size captured at request time, not the live core inputs.
    assign byte_lane = mem.data_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    assign half_lane = mem.data_rdata_i[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        case (size_q[1:0])
            2'b00:   load_data = {{24{byte_lane[7] & ~size_q[2]}}, byte_lane};
            2'b01:   load_data = {{16{half_lane[15] & ~size_q[2]}}, half_lane};
            default: load_data = mem.data_rdata_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (lsu_req_i) state_d = req_fault ? DONE : BUSY;
            BUSY:    if (mem.data_ack_i || (cnt_q == CNT_LAST)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (lsu_req_i) begin
                        if (req_fault) begin
                            err_q <= 1'b1;
                        end else begin
                            addr_q  <= lsu_addr_i;
                            we_q    <= lsu_we_i;
                            size_q  <= lsu_size_i;
                            be_q    <= be_d;
                            wdata_q <= wdata_d;
                            cnt_q   <= '0;
                        end
                    end
                end
                BUSY: begin
                    // An ack in the timeout cycle still completes the access normally.
                    if (mem.data_ack_i) begin
                        if (!we_q) rdata_q <= load_data;
                    end else if (cnt_q == CNT_LAST) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem.data_req_o   = (state_q == BUSY);
    assign mem.data_we_o    = we_q;
    assign mem.data_be_o    = be_q;
    assign mem.data_addr_o  = {addr_q[31:2], 2'b00};
    assign mem.data_wdata_o = wdata_q;

    assign lsu_data_o      = rdata_q;
    assign lsu_err_o       = err_q;
    assign lsu_stall_req_o = lsu_req_i && (state_q != DONE);

endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed self-checking bench for miriscv_lsu with ACK_TIMEOUT=4.
// Expected values are hand-computed from the load/store lane and extension rules.
module tb_miriscv_lsu;

    logic        clk_i = 1'b0;
    logic        arstn_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic [31:0] lsu_data_o;
    logic        lsu_stall_req_o;
    logic        lsu_err_o;

    int checks   = 0;
    int failures = 0;

    miriscv_lsu_if bus ();

    miriscv_lsu #(.ACK_TIMEOUT(4)) dut (
        .clk_i           (clk_i),
        .arstn_i         (arstn_i),
        .lsu_req_i       (lsu_req_i),
        .lsu_we_i        (lsu_we_i),
        .lsu_size_i      (lsu_size_i),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_data_i      (lsu_data_i),
        .lsu_data_o      (lsu_data_o),
        .lsu_stall_req_o (lsu_stall_req_o),
        .lsu_err_o       (lsu_err_o),
        .mem             (bus.master)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        stall_first;
        int          busy;
        logic        unstable;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          done_cycle;
        logic        err;
        logic [31:0] data;
        logic        err_after;
        logic        stall_after;
    } obs_t;

    // Drives one access from posedge+1; ack_wait = BUSY cycles without ack before ack (-1: never).
    task automatic run_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input int ack_wait,
                              input logic [31:0] rdata, output obs_t o);
        bit done = 0;
        o = '{default: '0};
        lsu_we_i   = we;
        lsu_size_i = size;
        lsu_addr_i = addr;
        lsu_data_i = wdata;
        lsu_req_i  = 1'b1;
        #1 o.stall_first = lsu_stall_req_o;
        for (int cyc = 2; cyc <= 20 && !done; cyc++) begin
            @(posedge clk_i); #1;
            if (bus.data_req_o) begin
                if (o.busy == 0) begin
                    o.we = bus.data_we_o; o.be = bus.data_be_o;
                    o.addr = bus.data_addr_o; o.wdata = bus.data_wdata_o;
                end else if (o.we !== bus.data_we_o || o.be !== bus.data_be_o ||
                             o.addr !== bus.data_addr_o || o.wdata !== bus.data_wdata_o) begin
                    o.unstable = 1'b1;
                end
                o.busy++;
                if (o.busy - 1 == ack_wait) begin
                    bus.data_ack_i = 1'b1; bus.data_rdata_i = rdata;
                end else begin
                    bus.data_ack_i = 1'b0; bus.data_rdata_i = 32'h0;
                end
            end else begin
                bus.data_ack_i = 1'b0;
                #1;
                if (!lsu_stall_req_o) begin
                    o.done_cycle = cyc; o.err = lsu_err_o; o.data = lsu_data_o; done = 1;
                end
            end
        end
        lsu_req_i = 1'b0;
        bus.data_ack_i = 1'b0;
        @(posedge clk_i); #1;
        o.err_after   = lsu_err_o;
        o.stall_after = lsu_stall_req_o;
    endtask

    task automatic test_reset();
        checks++; if (bus.data_req_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", bus.data_req_o); end
        checks++; if (bus.data_we_o !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", bus.data_we_o); end
        checks++; if (bus.data_be_o !== 4'h0) begin failures++; $display("FAIL rst_be got=%h exp=0", bus.data_be_o); end
        checks++; if (bus.data_addr_o !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", bus.data_addr_o); end
        checks++; if (bus.data_wdata_o !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", bus.data_wdata_o); end
        checks++; if (lsu_data_o !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", lsu_data_o); end
        checks++; if (lsu_err_o !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", lsu_err_o); end
        checks++; if (lsu_stall_req_o !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", lsu_stall_req_o); end
    endtask

    task automatic test_store_word();
        obs_t o;
        run_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0, o);
        checks++; if (o.stall_first !== 1'b1) begin failures++; $display("FAIL sw_stall_c1 got=%b exp=1", o.stall_first); end
        checks++; if (o.busy != 1) begin failures++; $display("FAIL sw_busy got=%0d exp=1", o.busy); end
        checks++; if (o.be !== 4'b1111) begin failures++; $display("FAIL sw_be got=%b exp=1111", o.be); end
        checks++; if (o.addr !== 32'h100) begin failures++; $display("FAIL sw_addr got=%h exp=00000100", o.addr); end
        checks++; if (o.wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_wdata got=%h exp=deadbeef", o.wdata); end
        checks++; if (o.we !== 1'b1) begin failures++; $display("FAIL sw_we got=%b exp=1", o.we); end
        checks++; if (o.done_cycle != 3) begin failures++; $display("FAIL sw_release_cycle got=%0d exp=3", o.done_cycle); end
        checks++; if (o.err !== 1'b0) begin failures++; $display("FAIL sw_err got=%b exp=0", o.err); end
    endtask

    task automatic test_load_byte();
        obs_t o;
        run_access(1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_FFFF, o);
        checks++; if (o.be !== 4'b1111) begin failures++; $display("FAIL lb_be got=%b exp=1111", o.be); end
        checks++; if (o.addr !== 32'h100) begin failures++; $display("FAIL lb_addr got=%h exp=00000100", o.addr); end
        checks++; if (o.we !== 1'b0) begin failures++; $display("FAIL lb_we got=%b exp=0", o.we); end
        checks++; if (o.data !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffff80", o.data); end
        run_access(1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF_FFFF, o);
        checks++; if (o.data !== 32'h0000_0080) begin failures++; $display("FAIL lbu_data got=%h exp=00000080", o.data); end
    endtask

    task automatic test_store_half_byte();
        obs_t o;
        run_access(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 0, 32'h0, o);
        checks++; if (o.be !== 4'b1100) begin failures++; $display("FAIL sh_be got=%b exp=1100", o.be); end
        checks++; if (o.wdata !== 32'hABCDABCD) begin failures++; $display("FAIL sh_wdata got=%h exp=abcdabcd", o.wdata); end
        checks++; if (o.addr !== 32'h100) begin failures++; $display("FAIL sh_addr got=%h exp=00000100", o.addr); end
        run_access(1'b1, 3'b000, 32'h101, 32'h000000A5, 0, 32'h0, o);
        checks++; if (o.be !== 4'b0010) begin failures++; $display("FAIL sb_be got=%b exp=0010", o.be); end
        checks++; if (o.wdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", o.wdata); end
    endtask

    task automatic test_load_half();
        obs_t o;
        run_access(1'b0, 3'b001, 32'h106, 32'h0, 0, 32'h8001_7FFF, o);
        checks++; if (o.addr !== 32'h104) begin failures++; $display("FAIL lh_addr got=%h exp=00000104", o.addr); end
        checks++; if (o.data !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_data got=%h exp=ffff8001", o.data); end
        run_access(1'b0, 3'b101, 32'h106, 32'h0, 0, 32'h8001_7FFF, o);
        checks++; if (o.data !== 32'h0000_8001) begin failures++; $display("FAIL lhu_data got=%h exp=00008001", o.data); end
    endtask

    task automatic test_load_word_wait();
        obs_t o;
        run_access(1'b0, 3'b010, 32'h200, 32'h0, 2, 32'h1357_9BDF, o);
        checks++; if (o.busy != 3) begin failures++; $display("FAIL lw_busy got=%0d exp=3", o.busy); end
        checks++; if (o.unstable !== 1'b0) begin failures++; $display("FAIL lw_stable got=%b exp=0", o.unstable); end
        checks++; if (o.done_cycle != 5) begin failures++; $display("FAIL lw_release_cycle got=%0d exp=5", o.done_cycle); end
        checks++; if (o.data !== 32'h1357_9BDF) begin failures++; $display("FAIL lw_data got=%h exp=13579bdf", o.data); end
        run_access(1'b1, 3'b010, 32'h204, 32'h0BAD_F00D, 0, 32'hFFFF_FFFF, o);
        checks++; if (o.data !== 32'h1357_9BDF) begin failures++; $display("FAIL sw_keeps_data got=%h exp=13579bdf", o.data); end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_access(1'b0, 3'b010, 32'h300, 32'h0, -1, 32'h0, o);
        checks++; if (o.busy != 4) begin failures++; $display("FAIL to_busy got=%0d exp=4", o.busy); end
        checks++; if (o.done_cycle != 6) begin failures++; $display("FAIL to_release_cycle got=%0d exp=6", o.done_cycle); end
        checks++; if (o.err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", o.err); end
        checks++; if (o.data !== 32'h1357_9BDF) begin failures++; $display("FAIL to_data got=%h exp=13579bdf", o.data); end
        checks++; if (o.err_after !== 1'b0) begin failures++; $display("FAIL to_err_pulse got=%b exp=0", o.err_after); end
        run_access(1'b0, 3'b010, 32'h300, 32'h0, 3, 32'h2468_ACE0, o);
        checks++; if (o.err !== 1'b0) begin failures++; $display("FAIL ack_at_to_err got=%b exp=0", o.err); end
        checks++; if (o.data !== 32'h2468_ACE0) begin failures++; $display("FAIL ack_at_to_data got=%h exp=2468ace0", o.data); end
    endtask

    task automatic test_illegal_size();
        obs_t o;
        run_access(1'b0, 3'b011, 32'h400, 32'h0, 0, 32'h0, o);
        checks++; if (o.busy != 0) begin failures++; $display("FAIL ill_busy got=%0d exp=0", o.busy); end
        checks++; if (o.done_cycle != 2) begin failures++; $display("FAIL ill_release_cycle got=%0d exp=2", o.done_cycle); end
        checks++; if (o.err !== 1'b1) begin failures++; $display("FAIL ill_err got=%b exp=1", o.err); end
        run_access(1'b1, 3'b111, 32'h400, 32'h0, 0, 32'h0, o);
        checks++; if (o.err !== 1'b1 || o.busy != 0) begin failures++; $display("FAIL ill7 got=err%b/busy%0d exp=err1/busy0", o.err, o.busy); end
    endtask

    task automatic test_misalign();
        obs_t o;
        run_access(1'b0, 3'b001, 32'h101, 32'h0, 0, 32'h1122_8344, o);
`ifdef MIRISCV_LSU_MISALIGN_EXC_EN
        checks++; if (o.busy != 0) begin failures++; $display("FAIL mis_busy got=%0d exp=0", o.busy); end
        checks++; if (o.done_cycle != 2) begin failures++; $display("FAIL mis_release_cycle got=%0d exp=2", o.done_cycle); end
        checks++; if (o.err !== 1'b1) begin failures++; $display("FAIL mis_err got=%b exp=1", o.err); end
`else
        checks++; if (o.busy != 1) begin failures++; $display("FAIL mis_busy got=%0d exp=1", o.busy); end
        checks++; if (o.addr !== 32'h100) begin failures++; $display("FAIL mis_addr got=%h exp=00000100", o.addr); end
        checks++; if (o.err !== 1'b0) begin failures++; $display("FAIL mis_err got=%b exp=0", o.err); end
        checks++; if (o.data !== 32'hFFFF_8344) begin failures++; $display("FAIL mis_data got=%h exp=ffff8344", o.data); end
`endif
    endtask

    task automatic test_back_to_back();
        obs_t o;
        run_access(1'b1, 3'b000, 32'h203, 32'h0000005A, 0, 32'h0, o);
        checks++; if (o.be !== 4'b1000 || o.wdata !== 32'h5A5A5A5A) begin failures++; $display("FAIL b2b_sb got=%b/%h exp=1000/5a5a5a5a", o.be, o.wdata); end
        run_access(1'b0, 3'b100, 32'h203, 32'h0, 0, 32'h5A00_0000, o);
        checks++; if (o.data !== 32'h0000_005A) begin failures++; $display("FAIL b2b_lbu got=%h exp=0000005a", o.data); end
        checks++; if (o.stall_after !== 1'b0) begin failures++; $display("FAIL b2b_idle_stall got=%b exp=0", o.stall_after); end
    endtask

    task automatic test_ack_outside_busy();
        bus.data_ack_i   = 1'b1;
        bus.data_rdata_i = 32'hCAFE_CAFE;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (bus.data_req_o !== 1'b0) begin failures++; $display("FAIL stray_ack_req got=%b exp=0", bus.data_req_o); end
        checks++; if (lsu_data_o !== 32'h0000_005A) begin failures++; $display("FAIL stray_ack_data got=%h exp=0000005a", lsu_data_o); end
        checks++; if (lsu_err_o !== 1'b0) begin failures++; $display("FAIL stray_ack_err got=%b exp=0", lsu_err_o); end
        bus.data_ack_i = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        lsu_we_i = 1'b0; lsu_size_i = 3'b010; lsu_addr_i = 32'h500; lsu_data_i = 32'h0;
        lsu_req_i = 1'b1;
        @(posedge clk_i); #1;
        checks++; if (bus.data_req_o !== 1'b1) begin failures++; $display("FAIL rmb_busy got=%b exp=1", bus.data_req_o); end
        arstn_i = 1'b0;
        #1;
        checks++; if (bus.data_req_o !== 1'b0) begin failures++; $display("FAIL rmb_req_now got=%b exp=0", bus.data_req_o); end
        lsu_req_i = 1'b0;
        @(posedge clk_i); #2;
        arstn_i = 1'b1;
        @(posedge clk_i); #1;
        checks++; if (bus.data_req_o !== 1'b0 || bus.data_we_o !== 1'b0 || bus.data_be_o !== 4'h0)
            begin failures++; $display("FAIL rmb_ctrl got=%b/%b/%h exp=0/0/0", bus.data_req_o, bus.data_we_o, bus.data_be_o); end
        checks++; if (bus.data_addr_o !== 32'h0 || bus.data_wdata_o !== 32'h0)
            begin failures++; $display("FAIL rmb_bus got=%h/%h exp=0/0", bus.data_addr_o, bus.data_wdata_o); end
        checks++; if (lsu_data_o !== 32'h0 || lsu_err_o !== 1'b0 || lsu_stall_req_o !== 1'b0)
            begin failures++; $display("FAIL rmb_core got=%h/%b/%b exp=0/0/0", lsu_data_o, lsu_err_o, lsu_stall_req_o); end
        @(posedge clk_i); #1;
        checks++; if (bus.data_req_o !== 1'b0) begin failures++; $display("FAIL rmb_no_retry got=%b exp=0", bus.data_req_o); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        arstn_i          = 1'b0;
        lsu_req_i        = 1'b0;
        lsu_we_i         = 1'b0;
        lsu_size_i       = 3'b000;
        lsu_addr_i       = 32'h0;
        lsu_data_i       = 32'h0;
        bus.data_ack_i   = 1'b0;
        bus.data_rdata_i = 32'h0;
        #12;
        test_reset();
        arstn_i = 1'b1;
        @(posedge clk_i); #1;
        test_store_word();
        test_load_byte();
        test_store_half_byte();
        test_load_half();
        test_load_word_wait();
        test_timeout();
        test_illegal_size();
        test_misalign();
        test_back_to_back();
        test_ack_outside_busy();
        test_reset_mid_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
